// File: rtl/dmux16_pkg.sv
// Shared types and constants for the 16-way demux feeder.
package dmux16_pkg;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NCHAN = 16;  // channels per word, one bit each
  localparam int SELW  = 4;   // width of the demux select / channel index
  localparam int CNTW  = 8;   // dwell counter width, covers DWELL up to 255

endpackage

// File: rtl/dwell_timer.sv
// Per-channel dwell counter for the demux feeder.
// Counts the cycles a channel has been selected and flags the last cycle of
// the dwell. The guard flag is evaluated on the count the counter will hold
// in the coming cycle, so the parent can register d0 and still have it line
// up with the select lines.
module dwell_timer
  import dmux16_pkg::*;
#(
  parameter int DWELL = 12,
  parameter int GUARD = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,       // synchronous clear, count restarts at 0
  output logic in_guard,  // next-cycle count < GUARD
  output logic last       // current count == DWELL-1
);

  localparam logic [CNTW-1:0] LAST_C  = CNTW'(DWELL - 1);
  localparam logic [CNTW-1:0] GUARD_C = CNTW'(GUARD);

  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;

  // Next count: clear wins, otherwise count up by one.
  always_comb begin
    count_d = clr ? '0 : count_q + 1'b1;
  end

  // Count register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples values
  // from before the edge, independent of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign last     = (count_q == LAST_C);
  assign in_guard = (count_d < GUARD_C);

endmodule

// File: rtl/dmux16_feeder.sv
// Upstream sequencer for the 16-way demultiplexer stage.
// Takes one 16-bit word per valid/ready handshake and walks it out bit by bit,
// channel 0 first, driving {s3,s2,s1,s0} with the channel index and d0 with
// the channel's bit. d0 is held low for the first GUARD cycles of every
// dwell so per-channel latches never see data while the select is changing.
// Every output except in_ready comes straight from a flop; those flops are
// loaded from the next-state values so RUN outputs appear the cycle after
// the capture edge.
module dmux16_feeder
  import dmux16_pkg::*;
#(
  parameter int DWELL = 12,  // cycles per channel, 2..255
  parameter int GUARD = 1    // leading cycles with d0 forced low, 0..DWELL-1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [NCHAN-1:0]  in_data,
  output logic              in_ready,
  input  logic              stop,
  output logic              s0,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              d0,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [SELW-1:0]   chan_q,  chan_d;
  logic [NCHAN-1:0]  shreg_q, shreg_d;
  logic [SELW-1:0]   sel_q,   sel_d;
  logic              d0_q,    d0_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic              timer_clr;
  logic              in_guard;
  logic              last;

  // The dwell count only runs in RUN; it restarts at each channel boundary
  // and whenever the word is aborted.
  assign timer_clr = (state_q != RUN) || last || stop;

  dwell_timer #(
    .DWELL (DWELL),
    .GUARD (GUARD)
  ) u_dwell_timer (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (timer_clr),
    .in_guard (in_guard),
    .last     (last)
  );

  // Next-state, channel, shift register and registered-output values.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d = state_q;
    chan_d  = chan_q;
    shreg_d = shreg_q;

    if (stop) begin
      // Abort from any state: drop the word, no done pulse.
      state_d = IDLE;
      chan_d  = '0;
      shreg_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // in_ready is high in IDLE, so in_valid alone completes the handshake.
          if (in_valid) begin
            shreg_d = in_data;
            chan_d  = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (last) begin
            shreg_d = shreg_q >> 1;
            if (chan_q == SELW'(NCHAN - 1)) state_d = DONE;
            else                            chan_d  = chan_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    sel_d  = (state_d == RUN) ? chan_d : '0;
    d0_d   = (state_d == RUN) && !in_guard && shreg_d[0];
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the shift register is cleared on reset as well, so a word
      // interrupted by reset can never leak into a later transfer.
      state_q <= IDLE;
      chan_q  <= '0;
      shreg_q <= '0;
      sel_q   <= '0;
      d0_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      shreg_q <= shreg_d;
      sel_q   <= sel_d;
      d0_q    <= d0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign s0       = sel_q[0];
  assign s1       = sel_q[1];
  assign s2       = sel_q[2];
  assign s3       = sel_q[3];
  assign d0       = d0_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dmux16_feeder.sv
// Directed bench for dmux16_feeder: one instance at DWELL=4/GUARD=1 for the
// main scenarios and one at DWELL=2/GUARD=0 for the parameter corner.
module tb_dmux16_feeder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stop;
  logic        va, vb;
  logic [15:0] da, db;

  logic ra, s0a, s1a, s2a, s3a, d0a, busya, donea;
  logic rb, s0b, s1b, s2b, s3b, d0b, busyb, doneb;

  int n_checks = 0;
  int n_pass   = 0;
  bit use_b    = 1'b0;

  logic [3:0] o_sel;
  logic       o_d0, o_busy, o_done, o_rdy;

  always #5 clk = ~clk;

  dmux16_feeder #(.DWELL(4), .GUARD(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .in_valid(va), .in_data(da), .in_ready(ra),
    .stop(stop), .s0(s0a), .s1(s1a), .s2(s2a), .s3(s3a), .d0(d0a),
    .busy(busya), .done(donea)
  );

  dmux16_feeder #(.DWELL(2), .GUARD(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .in_valid(vb), .in_data(db), .in_ready(rb),
    .stop(stop), .s0(s0b), .s1(s1b), .s2(s2b), .s3(s3b), .d0(d0b),
    .busy(busyb), .done(doneb)
  );

  // Observe whichever instance the current scenario targets.
  always_comb begin
    if (use_b) begin
      o_sel = {s3b, s2b, s1b, s0b}; o_d0 = d0b; o_busy = busyb;
      o_done = doneb; o_rdy = rb;
    end else begin
      o_sel = {s3a, s2a, s1a, s0a}; o_d0 = d0a; o_busy = busya;
      o_done = donea; o_rdy = ra;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic set_valid(input logic v, input logic [15:0] d);
    if (use_b) begin vb = v; db = d; end
    else       begin va = v; da = d; end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sel"},  o_sel,  0);
    check({tag, "_d0"},   o_d0,   0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_rdy"},  o_rdy,  1);
  endtask

  // Offer a word at the next falling edge and return just after the capture edge.
  task automatic send(input logic [15:0] data);
    @(negedge clk);
    set_valid(1'b1, data);
    check("rdy_at_offer", o_rdy, 1);
    @(posedge clk);
  endtask

  // Called right after capture edge N; checks cycles N+1..N+nmax against the
  // expected channel/dwell pattern. On the first cycle in_valid is set to
  // 'hold' and in_data to 'nxt'.
  task automatic word_cycles(input logic [15:0] data, input int dw, input int g,
                             input int nmax, input bit hold, input logic [15:0] nxt);
    int ch, pos;
    logic [3:0] e_sel;
    logic e_d0, e_busy, e_done, e_rdy;
    for (int j = 1; j <= nmax; j++) begin
      @(negedge clk);
      if (j == 1) set_valid(hold, nxt);
      if (j <= 16 * dw) begin
        ch = (j - 1) / dw; pos = (j - 1) % dw;
        e_sel = 4'(ch); e_d0 = (pos >= g) && data[ch];
        e_busy = 1'b1; e_done = 1'b0; e_rdy = 1'b0;
      end else if (j == 16 * dw + 1) begin
        e_sel = '0; e_d0 = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_rdy = 1'b0;
      end else begin
        e_sel = '0; e_d0 = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
      end
      check($sformatf("sel@N+%0d", j),  o_sel,  e_sel);
      check($sformatf("d0@N+%0d", j),   o_d0,   e_d0);
      check($sformatf("busy@N+%0d", j), o_busy, e_busy);
      check($sformatf("done@N+%0d", j), o_done, e_done);
      check($sformatf("rdy@N+%0d", j),  o_rdy,  e_rdy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; stop = 1'b0; va = 1'b0; vb = 1'b0; da = '0; db = '0;
    #1 rstn = 1'b0;

    // 1. Reset held for three cycles, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    rstn = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // 2. Single word: d0 = 0 in guard cycle, then in_data[k]; done at N+65.
    send(16'hA5C3);
    word_cycles(16'hA5C3, 4, 1, 66, 1'b0, 16'h0000);

    // 3. Back-to-back: in_valid held; second capture at edge N+66.
    send(16'hFFFF);
    word_cycles(16'hFFFF, 4, 1, 66, 1'b1, 16'h0001);
    @(posedge clk);
    word_cycles(16'h0001, 4, 1, 66, 1'b0, 16'h0000);

    // stop together with an offered word in IDLE: no capture.
    @(negedge clk);
    set_valid(1'b1, 16'hBEEF); stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("stop_vs_capture");
    set_valid(1'b0, 16'h0000); stop = 1'b0;

    // 4. Abort during channel 4, then accept a new word on the following edge.
    send(16'hFFFF);
    word_cycles(16'hFFFF, 4, 1, 19, 1'b0, 16'h0000);
    @(negedge clk);
    check("abort_sel_ch4", o_sel, 4);
    check("abort_d0_before", o_d0, 1);
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stop = 1'b0;
    check_idle("after_abort");
    set_valid(1'b1, 16'h1234);
    @(posedge clk);
    word_cycles(16'h1234, 4, 1, 66, 1'b0, 16'h0000);

    // 5. Asynchronous reset in cycle N+30, between clock edges.
    send(16'h00FF);
    word_cycles(16'h00FF, 4, 1, 29, 1'b0, 16'h0000);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_sel",  o_sel,  0);
    check("async_rst_d0",   o_d0,   0);
    check("async_rst_busy", o_busy, 0);
    check("async_rst_done", o_done, 0);
    check("async_rst_rdy",  o_rdy,  1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    send(16'h0003);
    word_cycles(16'h0003, 4, 1, 66, 1'b0, 16'h0000);

    // 6. DWELL=2, GUARD=0: d0 at N+1..N+2 and N+31..N+32, done at N+33.
    use_b = 1'b1;
    @(negedge clk);
    check_idle("corner_idle");
    send(16'h8001);
    word_cycles(16'h8001, 2, 0, 34, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmux16_feeder.md
# dmux16_feeder

Upstream sequencer for the 16-way demultiplexer stage. Accepts one 16-bit word per valid/ready handshake and presents it bit by bit on the demux select lines `s3..s0` and data line `d0`. Channel 0 is driven first and channel 15 last. Each channel is held for a programmable dwell with a leading guard interval in which `d0` is forced low, so downstream per-channel latches never see a glitch while the select lines change. Runs in the single 12 MHz system clock domain.

## Interface
- `DWELL`, 12: cycles each channel is selected; legal range 2..255.
- `GUARD`, 1: leading cycles of each dwell with `d0` forced 0; legal range 0..DWELL-1.

- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  `in_data` is offered.
- `in_data`  in  16  word to distribute; bit k goes to channel k.
- `in_ready`  out  1  block can accept a word.
- `stop`  in  1  synchronous abort; wins over all other activity.
- `s0`, `s1`, `s2`, `s3`  out  1 each  demux select, `{s3,s2,s1,s0}` = channel index.
- `d0`  out  1  demux data.
- `busy`  out  1  a word is being distributed.
- `done`  out  1  one-cycle pulse after channel 15 completes.

## Operation
- States: IDLE, RUN, DONE.
  - `in_ready` = (state == IDLE).
  - `busy` = (state == RUN).
- Reset: state IDLE, select = 0, `d0` = 0, `busy` = 0, `done` = 0, channel = 0, dwell count = 0. `in_ready` reads 1 while `rstn` is low.
- **IDLE.** On `in_valid & in_ready & !stop`:
  - capture `in_data` into a 16-bit shift register;
  - channel := 0, dwell := 0;
  - go to RUN.
  - `in_valid` without a capture has no effect. `in_data` is ignored except on the capture edge.
- **RUN.**
  - select = channel.
  - `d0` = 0 while dwell < GUARD; otherwise `d0` = current bit (shift register bit 0).
  - dwell increments each cycle. At dwell == DWELL-1: dwell := 0 and the shift register shifts right by one.
  - If channel == 15 at that point, go to DONE; otherwise channel := channel + 1.
  - The channel counter is 4 bits wide and never wraps inside a word.
- **DONE.** `done` = 1 for exactly one cycle; select = 0, `d0` = 0. Next state is IDLE.
- **`stop`.** Synchronous, in any state. Next state is IDLE, select := 0, `d0` := 0, shift register cleared, and no `done` pulse.
  - `stop` together with an `in_valid` capture in IDLE: no capture.
- **Mid-operation reset.** `rstn` low in RUN or DONE immediately forces all reset values and discards the word.
- **Register placement.** All outputs except `in_ready` come directly from flops.

## Timing
- Capture on edge N. RUN outputs are visible from cycle N+1.
- Channel k occupies cycles N+1+k·DWELL through N+(k+1)·DWELL.
  - `d0` = 0 for the first GUARD cycles of that window.
  - `d0` = `in_data[k]` for the remaining DWELL-GUARD cycles.
- `done` is high during cycle N+1+16·DWELL. `in_ready` rises in cycle N+2+16·DWELL.
- Throughput: one word per 16·DWELL+2 cycles. At the defaults (DWELL=12) that is 194 cycles, about 16.2 µs at 12 MHz.
- GUARD=0: `d0` changes on the same edge as the select lines.

## Structure
- Package `dmux16_pkg` holds:
  - state enumeration (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - `NCHAN` = 16 and `SELW` = 4;
  - dwell counter width, 8 bits.
- One sub-module, `dwell_timer`:
  - 8-bit up-counter with synchronous clear;
  - outputs `in_guard` (count < GUARD) and `last` (count == DWELL-1).
- The parent holds the FSM, the channel counter and the shift register.

## Test plan
- All scenarios use DWELL=4, GUARD=1 unless stated.
1. **Reset.** Hold `rstn`=0 for 3 cycles, then release → select = 0, `d0`=0, `busy`=0, `done`=0, `in_ready`=1.
2. **Single word.** `in_data`=16'hA5C3 accepted at edge N →
   - channel k selected for cycles N+1+4k through N+4+4k;
   - `d0`=0 in the first cycle of each window, `in_data[k]` in the other 3;
   - `done` high at N+65 only; `in_ready`=1 at N+66.
3. **Back-to-back words.** Words 16'hFFFF then 16'h0001, `in_valid` held high →
   - second capture at N+66;
   - during word 2, `d0`=1 only at cycles N+68..N+70 (channel 0).
4. **Abort.** Assert `stop` at cycle N+20 (channel 4) → next cycle IDLE, select = 0, `d0`=0, no `done`; a new word is accepted on the following edge.
5. **Async reset mid-word.** `rstn` low at N+30, between clock edges → outputs reach reset values without waiting for a clock edge; after release, the bench checks that channel 0 restarts on the next accepted word.
6. **Parameter corners.** DWELL=2, GUARD=0, `in_data`=16'h8001 → `d0`=1 at N+1..N+2 and N+31..N+32 only; `done` at N+33.
